// File: rtl/ps2_keyboard_matrix_if.sv
// ps2_keyboard_matrix_if
// Groups the keyboard-side and ULA-side signals of the PS/2 keyboard matrix.
//   ps2clk, ps2data : raw PS/2 lines from the keyboard (asynchronous to clk28)
//   rows            : CPU A15..A8, a 0 bit selects that half-row
//   kbd             : active-low column data returned to the ULA
//   reset_req       : one-cycle pulse on Ctrl+Alt+Del
//   frame_err       : one-cycle pulse on parity, stop-bit or timeout error
// The master modport is the host/bench side; the slave modport is the block.
interface ps2_keyboard_matrix_if;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] rows;
    logic [4:0] kbd;
    logic       reset_req;
    logic       frame_err;

    modport master (
        output ps2clk, ps2data, rows,
        input  kbd, reset_req, frame_err
    );

    modport slave (
        input  ps2clk, ps2data, rows,
        output kbd, reset_req, frame_err
    );
endinterface

// File: rtl/ps2_keyboard_matrix.sv
// ps2_keyboard_matrix
// Receives PS/2 set-2 scancodes and maintains the 8x5 ZX Spectrum key
// matrix, returning active-low column data for the half-rows selected by
// the CPU address lines. Also pulses reset_req on Ctrl+Alt+Del.
// Ports:
//   clk28 : 28 MHz master clock, the only clock
//   rst_n : asynchronous active-low reset
//   bus   : ps2_keyboard_matrix_if slave modport (ps2clk, ps2data, rows in;
//           kbd, reset_req, frame_err out)
// Parameter:
//   TIMEOUT_CYCLES : clk28 cycles without a bit strobe before a partial
//                    frame is abandoned
module ps2_keyboard_matrix #(
    parameter int TIMEOUT_CYCLES = 28000
) (
    input  logic                  clk28,
    input  logic                  rst_n,
    ps2_keyboard_matrix_if.slave  bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic            ps2clk_meta, ps2clk_sync;
    logic            ps2data_meta, ps2data_sync;
    logic [3:0]      filt_sr;
    logic            clk_filt;
    logic            strobe;

    rx_state_t       state, state_nxt;
    logic [7:0]      shift_reg;
    logic [2:0]      bit_cnt;
    logic            parity_bit;
    logic            parity_ok;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit;
    logic            byte_done, rx_err;
    logic            byte_rdy, frame_err_q;

    logic [39:0]     matrix;
    logic            ext, brk, ctrl, alt;
    logic [2:0]      skip_cnt;
    logic            reset_req_q;
    logic            map_hit;
    logic [5:0]      map_idx;
    logic [4:0]      kbd_c;

    // Synchronise both PS/2 lines, then debounce the clock: the filtered
    // level only moves once four consecutive samples agree. The strobe
    // fires on the cycle the filtered clock falls.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            ps2clk_meta  <= 1'b1;
            ps2clk_sync  <= 1'b1;
            ps2data_meta <= 1'b1;
            ps2data_sync <= 1'b1;
            filt_sr      <= 4'hF;
            clk_filt     <= 1'b1;
            strobe       <= 1'b0;
        end else begin
            ps2clk_meta  <= bus.ps2clk;
            ps2clk_sync  <= ps2clk_meta;
            ps2data_meta <= bus.ps2data;
            ps2data_sync <= ps2data_meta;
            filt_sr      <= {filt_sr[2:0], ps2clk_sync};
            if (filt_sr == 4'hF) begin
                clk_filt <= 1'b1;
            end else if (filt_sr == 4'h0) begin
                clk_filt <= 1'b0;
            end
            strobe <= clk_filt && (filt_sr == 4'h0);
        end
    end

    // Odd parity over the eight data bits plus the parity bit.
    assign parity_ok   = ^{shift_reg, parity_bit};
    assign timeout_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

    // Receiver state register.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Receiver next-state logic; a timeout overrides any strobe.
    always_comb begin
        state_nxt = state;
        if (timeout_hit) begin
            state_nxt = IDLE;
        end else if (strobe) begin
            case (state)
                IDLE:    if (!ps2data_sync) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Receiver outputs: good byte or framing error, decided at the stop bit.
    always_comb begin
        byte_done = 1'b0;
        rx_err    = 1'b0;
        if (timeout_hit) begin
            rx_err = 1'b1;
        end else if (strobe && (state == STOP)) begin
            if (ps2data_sync && parity_ok) begin
                byte_done = 1'b1;
            end else begin
                rx_err = 1'b1;
            end
        end
    end

    // Receiver datapath: LSB-first shifter, bit counter, inter-strobe timer
    // and the registered byte_rdy / frame_err pulses.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= 8'h00;
            bit_cnt     <= 3'd0;
            parity_bit  <= 1'b0;
            to_cnt      <= '0;
            byte_rdy    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_rdy    <= byte_done;
            frame_err_q <= rx_err;
            if (strobe || (state == IDLE)) begin
                to_cnt <= '0;
            end else if (!timeout_hit) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (state == IDLE) begin
                bit_cnt <= 3'd0;
            end
            if (strobe && !timeout_hit) begin
                if (state == DATA) begin
                    shift_reg <= {ps2data_sync, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end else if (state == PARITY) begin
                    parity_bit <= ps2data_sync;
                end
            end
        end
    end

    // Scancode to matrix position, as row*5+col.
    always_comb begin
        map_hit = 1'b1;
        map_idx = 6'd0;
        if (ext) begin
            case (shift_reg)
                8'h14:   map_idx = 6'd36;
                8'h5A:   map_idx = 6'd30;
                default: map_hit = 1'b0;
            endcase
        end else begin
            case (shift_reg)
                8'h12: map_idx = 6'd0;   8'h1A: map_idx = 6'd1;
                8'h22: map_idx = 6'd2;   8'h21: map_idx = 6'd3;
                8'h2A: map_idx = 6'd4;   8'h1C: map_idx = 6'd5;
                8'h1B: map_idx = 6'd6;   8'h23: map_idx = 6'd7;
                8'h2B: map_idx = 6'd8;   8'h34: map_idx = 6'd9;
                8'h15: map_idx = 6'd10;  8'h1D: map_idx = 6'd11;
                8'h24: map_idx = 6'd12;  8'h2D: map_idx = 6'd13;
                8'h2C: map_idx = 6'd14;  8'h16: map_idx = 6'd15;
                8'h1E: map_idx = 6'd16;  8'h26: map_idx = 6'd17;
                8'h25: map_idx = 6'd18;  8'h2E: map_idx = 6'd19;
                8'h45: map_idx = 6'd20;  8'h46: map_idx = 6'd21;
                8'h3E: map_idx = 6'd22;  8'h3D: map_idx = 6'd23;
                8'h36: map_idx = 6'd24;  8'h4D: map_idx = 6'd25;
                8'h44: map_idx = 6'd26;  8'h43: map_idx = 6'd27;
                8'h3C: map_idx = 6'd28;  8'h35: map_idx = 6'd29;
                8'h5A: map_idx = 6'd30;  8'h4B: map_idx = 6'd31;
                8'h42: map_idx = 6'd32;  8'h3B: map_idx = 6'd33;
                8'h33: map_idx = 6'd34;  8'h29: map_idx = 6'd35;
                8'h14: map_idx = 6'd36;  8'h3A: map_idx = 6'd37;
                8'h31: map_idx = 6'd38;  8'h32: map_idx = 6'd39;
                default: map_hit = 1'b0;
            endcase
        end
    end

    // Scancode decoder. Prefixes (E0/F0) persist until a code consumes
    // them; E1 starts the 7-byte Pause sequence, which is swallowed whole.
    // Modifier tracking ignores ext, so left and right Ctrl/Alt both count.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            matrix      <= '1;
            ext         <= 1'b0;
            brk         <= 1'b0;
            ctrl        <= 1'b0;
            alt         <= 1'b0;
            skip_cnt    <= 3'd0;
            reset_req_q <= 1'b0;
        end else begin
            reset_req_q <= 1'b0;
            if (byte_rdy) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else begin
                    case (shift_reg)
                        8'hE0: ext      <= 1'b1;
                        8'hF0: brk      <= 1'b1;
                        8'hE1: skip_cnt <= 3'd7;
                        8'hAA, 8'h00, 8'hFF: begin
                            matrix <= '1;
                            ext    <= 1'b0;
                            brk    <= 1'b0;
                        end
                        8'hFA, 8'hEE, 8'hFE: begin
                        end
                        default: begin
                            if (map_hit) begin
                                matrix[map_idx] <= brk;
                            end
                            if (shift_reg == 8'h14) begin
                                ctrl <= !brk;
                            end
                            if (shift_reg == 8'h11) begin
                                alt <= !brk;
                            end
                            if (ext && !brk && (shift_reg == 8'h71) && ctrl && alt) begin
                                reset_req_q <= 1'b1;
                            end
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Column read-out: AND of every selected half-row, all ones if none.
    always_comb begin
        kbd_c = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!bus.rows[r]) begin
                for (int c = 0; c < 5; c++) begin
                    kbd_c[c] = kbd_c[c] & matrix[r*5 + c];
                end
            end
        end
    end

    assign bus.kbd       = kbd_c;
    assign bus.reset_req = reset_req_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// tb_ps2_keyboard_matrix
// Directed bench for ps2_keyboard_matrix. Stimulus tasks push expected
// column reads and expected pulses into queues; an independent monitor
// pops and compares whenever a column read is presented or a pulse appears.
module tb_ps2_keyboard_matrix;

    localparam int TO   = 400;
    localparam int HALF = 20;
    localparam int GAP  = 60;

    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    logic kbd_valid = 1'b0;

    ps2_keyboard_matrix_if bus ();

    ps2_keyboard_matrix #(.TIMEOUT_CYCLES(TO)) dut (
        .clk28 (clk28),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk28 = ~clk28;

    logic [4:0]  kbd_exp_q[$];
    string       kbd_name_q[$];
    logic [7:0]  pulse_q[$];
    int          checks_total  = 0;
    int          checks_passed = 0;
    int          reset_req_seen = 0;
    int          frame_err_seen = 0;

    // Compare an observed pulse against the next expected pulse kind.
    task automatic popPulse(input logic [7:0] kind, input string name);
        logic [7:0] exp;
        checks_total++;
        if (pulse_q.size() == 0) begin
            $display("[TB] FAIL %s: unexpected pulse, none pending", name);
        end else begin
            exp = pulse_q.pop_front();
            if (exp == kind) checks_passed++;
            else $display("[TB] FAIL %s: got pulse '%c', expected '%c'", name, kind, exp);
        end
    endtask

    // Monitor: checks column reads when presented and every output pulse.
    initial begin
        logic [4:0] exp;
        string      nm;
        forever begin
            @(negedge clk28);
            if (kbd_valid) begin
                checks_total++;
                if (kbd_exp_q.size() == 0) begin
                    $display("[TB] FAIL kbd_read: no expectation queued, kbd=%b", bus.kbd);
                end else begin
                    exp = kbd_exp_q.pop_front();
                    nm  = kbd_name_q.pop_front();
                    if (bus.kbd === exp) checks_passed++;
                    else $display("[TB] FAIL %s: kbd=%b expected %b", nm, bus.kbd, exp);
                end
            end
            if (bus.reset_req === 1'b1) begin
                reset_req_seen++;
                popPulse("R", "reset_req");
            end
            if (bus.frame_err === 1'b1) begin
                frame_err_seen++;
                popPulse("E", "frame_err");
            end
        end
    end

    // Send one PS/2 frame (or its first nbits bits), optionally corrupted.
    task automatic applyStimulus(input logic [7:0] code, input logic bad_par,
                                 input logic bad_stop, input int nbits);
        logic [10:0] frame;
        frame = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2data = frame[i];
            repeat (HALF) @(posedge clk28);
            bus.ps2clk = 1'b0;
            repeat (HALF) @(posedge clk28);
            bus.ps2clk = 1'b1;
        end
        bus.ps2data = 1'b1;
        repeat (GAP) @(posedge clk28);
    endtask

    task automatic sendByte(input logic [7:0] code);
        applyStimulus(code, 1'b0, 1'b0, 11);
    endtask

    // Drive a row selection and queue the expected column read.
    task automatic checkOutput(input logic [7:0] r, input logic [4:0] exp, input string name);
        @(posedge clk28);
        #1;
        bus.rows = r;
        kbd_exp_q.push_back(exp);
        kbd_name_q.push_back(name);
        kbd_valid = 1'b1;
        @(posedge clk28);
        #1;
        kbd_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.ps2clk  = 1'b1;
        bus.ps2data = 1'b1;
        bus.rows    = 8'hFF;
        repeat (5) @(posedge clk28);
        checkOutput(8'h00, 5'b11111, "reset_all_rows");
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk28);
        checkOutput(8'h00, 5'b11111, "after_reset");

        // Make and break of A.
        sendByte(8'h1C);
        checkOutput(8'hFD, 5'b11110, "make_A");
        checkOutput(8'hFF, 5'b11111, "no_row_selected");
        sendByte(8'hF0); sendByte(8'h1C);
        checkOutput(8'hFD, 5'b11111, "break_A");

        // Multiple keys and AND across rows.
        sendByte(8'h12); sendByte(8'h1A);
        checkOutput(8'hFE, 5'b11100, "caps_z_row0");
        sendByte(8'h1C);
        checkOutput(8'hFC, 5'b11100, "and_rows_0_1");
        checkOutput(8'hFD, 5'b11110, "row1_A_only");
        checkOutput(8'hFF, 5'b11111, "rows_ff");
        sendByte(8'hF0); sendByte(8'h1C);
        sendByte(8'hF0); sendByte(8'h12);
        sendByte(8'hF0); sendByte(8'h1A);
        checkOutput(8'h00, 5'b11111, "all_released");

        // Framing errors leave the matrix alone.
        pulse_q.push_back("E");
        applyStimulus(8'h1C, 1'b1, 1'b0, 11);
        checkOutput(8'hFD, 5'b11111, "bad_parity_ignored");
        pulse_q.push_back("E");
        applyStimulus(8'h1C, 1'b0, 1'b1, 11);
        checkOutput(8'hFD, 5'b11111, "bad_stop_ignored");

        // Stalled partial frame times out, then a clean frame decodes.
        pulse_q.push_back("E");
        applyStimulus(8'h1C, 1'b0, 1'b0, 5);
        repeat (TO + 50) @(posedge clk28);
        checkOutput(8'hFD, 5'b11111, "timeout_no_key");
        sendByte(8'h1C);
        checkOutput(8'hFD, 5'b11110, "after_timeout_A");
        sendByte(8'hF0); sendByte(8'h1C);

        // Ctrl+Alt+Del, then Del without modifiers.
        pulse_q.push_back("R");
        sendByte(8'h14); sendByte(8'h11); sendByte(8'hE0); sendByte(8'h71);
        checkOutput(8'h7F, 5'b11101, "symb_held");
        sendByte(8'hF0); sendByte(8'h14); sendByte(8'hF0); sendByte(8'h11);
        sendByte(8'hE0); sendByte(8'h71);
        checkOutput(8'h7F, 5'b11111, "symb_released");

        // BAT clears everything.
        sendByte(8'h12); sendByte(8'h1C); sendByte(8'h29);
        checkOutput(8'h7E, 5'b11110, "caps_space_held");
        checkOutput(8'hFD, 5'b11110, "a_held");
        sendByte(8'hAA);
        checkOutput(8'h00, 5'b11111, "bat_clears");

        // Pause sequence is swallowed; the next byte decodes normally.
        sendByte(8'hE1); sendByte(8'h14); sendByte(8'h77); sendByte(8'hE1);
        sendByte(8'hF0); sendByte(8'h14); sendByte(8'hF0); sendByte(8'h77);
        checkOutput(8'h00, 5'b11111, "pause_ignored");
        sendByte(8'h1C);
        checkOutput(8'hFD, 5'b11110, "after_pause_A");

        // Typematic repeat, double F0, break of unpressed key.
        sendByte(8'h1C);
        checkOutput(8'hFD, 5'b11110, "typematic_A");
        sendByte(8'hF0); sendByte(8'hF0); sendByte(8'h1C);
        checkOutput(8'hFD, 5'b11111, "double_f0_break");
        sendByte(8'hF0); sendByte(8'h1A);
        checkOutput(8'hFE, 5'b11111, "break_unpressed");

        // Extended map: right Enter on r6c0, other E0 codes unmapped.
        sendByte(8'hE0); sendByte(8'h5A);
        checkOutput(8'hBF, 5'b11110, "ext_enter");
        sendByte(8'hE0); sendByte(8'h1C);
        checkOutput(8'hFD, 5'b11111, "ext_unmapped");
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h5A);
        checkOutput(8'hBF, 5'b11111, "ext_enter_break");

        // Reset in the middle of a frame.
        sendByte(8'h1C);
        checkOutput(8'hFD, 5'b11110, "pre_reset_A");
        applyStimulus(8'h35, 1'b0, 1'b0, 4);
        @(posedge clk28);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk28);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk28);
        checkOutput(8'hFD, 5'b11111, "midframe_reset_clears");
        sendByte(8'h1C);
        checkOutput(8'hFD, 5'b11110, "post_reset_A");

        repeat (100) @(posedge clk28);
        checks_total++;
        if (pulse_q.size() == 0) checks_passed++;
        else $display("[TB] FAIL pending_pulses: %0d left, expected 0", pulse_q.size());
        checks_total++;
        if (reset_req_seen == 1) checks_passed++;
        else $display("[TB] FAIL reset_req_count: got %0d, expected 1", reset_req_seen);
        checks_total++;
        if (frame_err_seen == 3) checks_passed++;
        else $display("[TB] FAIL frame_err_count: got %0d, expected 3", frame_err_seen);
        checks_total++;
        if (kbd_exp_q.size() == 0) checks_passed++;
        else $display("[TB] FAIL pending_reads: %0d left, expected 0", kbd_exp_q.size());

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_matrix.md
# ps2_keyboard_matrix

Receives PS/2 set-2 scancodes from a PC keyboard and maintains the 8x5 ZX Spectrum key matrix. Drives the ULA `kbd[4:0]` input, which the ULA returns on port $FE reads. Row selection comes from CPU address lines A15..A8. It also emits a one-cycle reset request on Ctrl+Alt+Del.

## Interface
- `TIMEOUT_CYCLES`, default 28000: clk28 cycles (~1 ms) without a PS/2 clock edge before a partial frame is abandoned.
- `clk28  in  1`: 28 MHz master clock; the only clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `ps2clk  in  1`: raw PS/2 clock line, asynchronous to clk28.
- `ps2data  in  1`: raw PS/2 data line, asynchronous to clk28.
- `rows  in  8`: CPU A15..A8; a 0 bit selects that half-row.
- `kbd  out  5`: column data, active-low (0 = key pressed).
- `reset_req  out  1`: one-cycle pulse on the Del make code while Ctrl and Alt are held.
- `frame_err  out  1`: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Input conditioning.** ps2clk and ps2data each pass through a 2-FF synchroniser. ps2clk then passes a 4-sample filter, and its level changes only when 4 consecutive samples agree. A falling edge of the filtered clock is a bit strobe, and ps2data (synchronised) is sampled on it.
- **Receiver FSM**, with states IDLE, DATA, PARITY and STOP:
  - IDLE -> DATA when the strobe sees data = 0 (start bit). A 1 stays in IDLE.
  - DATA shifts 8 bits, LSB first, then moves to PARITY.
  - PARITY checks for odd parity over the 8 data bits plus the parity bit.
  - STOP requires 1. If parity and stop are good, assert `byte_rdy` for one cycle; otherwise pulse `frame_err`. Both cases return to IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES since the last strobe goes to IDLE and pulses `frame_err`.
- **Decoder.** Holds flags `ext` (E0 seen), `brk` (F0 seen), a pause-skip counter, and `ctrl`/`alt` states. On each good byte:
  - E0: set `ext`. F0: set `brk`.
  - E1: load the skip counter with 7. While it is nonzero, each byte decrements it and is otherwise ignored.
  - AA (BAT), 00 or FF (overrun): set all 40 matrix bits to 1 and clear `ext`/`brk`.
  - FA, EE, FE: ignored.
  - Any other code: map it to (row, col). Write matrix[row][col] = `brk` (make writes 0, break writes 1). Then clear `ext` and `brk`. Unmapped codes only clear the flags.
- **Non-extended map**, listed per row as col0..col4 with set-2 hex codes:
  - r0: 12 (CAPS, left shift), 1A, 22, 21, 2A
  - r1: 1C, 1B, 23, 2B, 34
  - r2: 15, 1D, 24, 2D, 2C
  - r3: 16, 1E, 26, 25, 2E
  - r4: 45, 46, 3E, 3D, 36
  - r5: 4D, 44, 43, 3C, 35
  - r6: 5A, 4B, 42, 3B, 33
  - r7: 29, 14 (SYMB, left ctrl), 3A, 31, 32
- **Extended map:** E0 14 -> r7c1 and E0 5A -> r6c0. Every other E0 code is unmapped.
- **Modifier tracking.** `ctrl` tracks 14 and E0 14. `alt` tracks 11 and E0 11. A make of E0 71 with `ctrl` and `alt` both set pulses `reset_req`.
- **Output.** `kbd[c]` is the AND of matrix[r][c] over every r with rows[r]=0. The path is combinational from `rows` and the matrix. If no row is selected, `kbd = 5'b11111`.

## Timing
- **Reset values:**
  - Matrix all 1, so `kbd = 11111` for any `rows`.
  - `reset_req` = 0 and `frame_err` = 0.
  - FSM in IDLE; `ext`, `brk`, `ctrl`, `alt` cleared; skip counter = 0.
  - Reset mid-frame discards the partial byte.
- **Strobe latency:** 2 synchroniser cycles plus 4 filter cycles from the raw ps2clk fall.
- **Byte to key:** `byte_rdy` fires on the cycle after the stop-bit strobe, and the matrix bit updates on the following clk28 edge. `kbd` reflects it combinationally in that same cycle.
- **Pulse widths:** `reset_req` and `frame_err` are exactly 1 clk28 cycle.
- **Ordering rules:**
  - A byte arriving while a prefix is pending uses the prefix.
  - A second F0 before a code is idempotent.
  - A make for an already-pressed key is idempotent, covering typematic repeat.
  - A break for a key that is not pressed leaves it at 1.

## Test plan
- Frame 1C (make A), then set rows = 8'hFD -> `kbd = 11110`. Frames F0 1C -> `kbd = 11111`.
- Press 12 and 1A, set rows = 8'hFE -> `kbd = 11100`. Set rows = 8'hFC with A held -> `kbd = 11100` (AND across rows). Set rows = 8'hFF -> `kbd = 11111`.
- Frame with bad parity for 1C -> `frame_err` pulses, matrix unchanged. Stop bit 0 -> same result.
- Send start plus 4 bits then stall TIMEOUT_CYCLES+1 -> `frame_err` pulses. A following full 1C frame is decoded correctly.
- Sequence 14, 11, E0 71 -> single 1-cycle `reset_req`. E0 71 alone -> no pulse.
- Press several keys, then send AA -> all 1s. E1 14 77 E1 F0 14 F0 77 -> matrix unchanged, no SYMB latched. Assert rst_n low mid-frame -> matrix cleared, FSM IDLE.
